mmio_display: RTL and testbench
===============================

# mmio_display

Memory-mapped LED and 4-digit seven-segment display controller sitting directly downstream of the pipelined CPU's MEM stage. It sits on the same address/data/strobe signals the data memory sees, decodes its own 16-byte window, and holds the LED and digit registers. It time-multiplexes the four digits onto shared segment/anode pins using a free-running scan counter. Reads are combinational so the MEM stage can return them in the same cycle, like data memory reads.

## Interface
Parameters:
- `BASE_ADDR`, `32'h4000_0010`: byte address of register 0; the window is `BASE_ADDR .. BASE_ADDR+15`.
- `SCAN_DIV`, `50000`: clock cycles each digit stays lit; legal range 2..2^20.

Ports:
- `clk`  in  1  CPU pipeline clock (the divided slow clock).
- `reset`  in  1  asynchronous, active-high.
- `addr`  in  32  byte address from the MEM stage ALU result.
- `wr_en`  in  1  MemWrite from the MEM stage.
- `rd_en`  in  1  MemRead from the MEM stage.
- `wr_data`  in  32  store data, already forwarded.
- `rd_data`  out  32  read data; 0 when not selected.
- `sel`  out  1  high when `addr` is inside the window; the top level uses it to mux `rd_data` against data memory.
- `led`  out  8  LED register contents.
- `seg`  out  7  segments, active-low, bit order `{g,f,e,d,c,b,a}`.
- `ano`  out  4  anodes, active-low one-hot; `ano[0]` is the rightmost digit.

## Operation
- `sel` = (`addr[31:4]` == `BASE_ADDR[31:4]`). `addr[1:0]` is ignored; all accesses are word accesses.
- Register map (offset, meaning):
  - 0x0 LED: R/W, bits 7:0.
  - 0x4 DIGITS: R/W; bits 15:0 hold four nibbles, digit i = bits [4i+3:4i].
  - 0x8 CTRL: R/W; bit0 `en` (reset value 1), bit1 `blank_lz` (suppress leading zeros, reset value 0).
  - 0xC STATUS: RO; bits 1:0 = current digit index, bits 31:16 = frame counter. Writes to STATUS are ignored.
- Write: when `wr_en && sel`, the addressed register updates at the next clock edge. Unused bits are written as 0 and read as 0.
- Read: `rd_data` = register value when `rd_en && sel`, otherwise 0. The read path is purely combinational.
- Scan:
  - `div_cnt` counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, `div_cnt` wraps to 0 and `idx` increments mod 4.
  - When `idx` wraps 3→0: `shadow` ← DIGITS, and `frame` increments, wrapping at 16 bits.
- Anti-tearing: the display always shows `shadow`, never DIGITS directly. A DIGITS write becomes visible at the next frame boundary.
- `en` = 0:
  - `div_cnt`, `idx` and `frame` are held at 0.
  - `ano` = 4'b1111 and `seg` = 7'h7F.
  - `shadow` loads DIGITS every cycle, so re-enabling shows current data immediately.
- `blank_lz`: digit i (i ≥ 1) is blanked (`ano` bit stays high) if it and every higher digit are 0. Digit 0 is never blanked.
- Simultaneous write to DIGITS on a frame-boundary cycle: `shadow` takes the old value and the new value appears one frame later.

## Timing
- Reset values: LED=0, DIGITS=0, CTRL=2'b01, `div_cnt`=0, `idx`=0, `frame`=0, `shadow`=0, `seg`=7'h7F, `ano`=4'b1111.
- `seg` and `ano` are registered and lag `idx`/`shadow` by one cycle. The first digit appears on the first edge after reset deasserts, with `seg`=7'b1000000 ("0") and `ano`=4'b1110.
- `led` is driven directly from its register, so it changes one edge after the write.
- One frame lasts 4·SCAN_DIV cycles.
- Reset asserted mid-scan returns all state to the reset values immediately (asynchronously).

## Configuration
- `MMIO_DISPLAY_HEX_EN` defined:
  - Each nibble is decoded to hex glyphs 0–F.
  - DIGITS is 16 bits wide.
- Not defined:
  - Raw mode: DIGITS is 32 bits, and byte i drives digit i's `seg` directly (bits 6:0, active-low; bit 7 ignored).
  - `blank_lz` compares whole bytes against 8'hFF (all segments off) instead of 0.
  - Reset value of DIGITS/`shadow` is 32'hFFFF_FFFF.

## Structure
- Package `mmio_display_pkg`:
  - Register offset constants `OFF_LED`, `OFF_DIGITS`, `OFF_CTRL`, `OFF_STATUS`.
  - CTRL bit positions.
  - Blank pattern 7'h7F.
- One sub-module: `hex7seg`, a combinational nibble-to-active-low-segment decoder. It is instantiated only under `MMIO_DISPLAY_HEX_EN`.

## Test plan
All scenarios use SCAN_DIV=4 and the hex build unless stated.
- Reset → `ano`=1111, `seg`=7F; one edge after release → `ano`=1110, `seg`=1000000; `rd_data`=0 with `rd_en`=0.
- Write 0x1234 to BASE+4, then watch the next frame → digits read `4`,`3`,`2`,`1` on `ano` 1110,1101,1011,0111, 4 cycles each. A read of BASE+4 in the same cycle as `rd_en` returns 0x1234.
- Write DIGITS in mid-frame (`idx`=1) → old value stays on `seg` until `idx` wraps to 0; STATUS[31:16] increments by 1 per 16 cycles.
- Write CTRL=0 → `ano`=1111 and STATUS=0. Write CTRL=1 → scan restarts at `idx` 0 showing current DIGITS.
- CTRL=3 with DIGITS=0x0050 → digits 3 and 2 blank; digits 1 and 0 show `5` and `0`. DIGITS=0 → only digit 0 lit.
- Write LED=0xA5 at BASE+0; write to BASE+0xC; access outside the window (BASE+0x10) → `led`=A5, STATUS is unchanged, and `sel`=0 with `rd_data`=0 for the out-of-window access.

Source files
------------

// File: rtl/mmio_display_pkg.sv
// mmio_display shared constants: register offsets, CTRL bits, blank glyph.
// MMIO_DISPLAY_HEX_EN selects hex-decoded 16-bit DIGITS over raw 32-bit segments.
package mmio_display_pkg;

  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_DIGITS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_BLZ = 1;
  localparam logic [1:0] CTRL_RST = 2'b01;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

`ifdef MMIO_DISPLAY_HEX_EN
  localparam int DIG_W = 16;
  localparam logic [DIG_W-1:0] DIG_RST = '0;
`else
  localparam int DIG_W = 32;
  localparam logic [DIG_W-1:0] DIG_RST = '1;
`endif

endpackage

// File: rtl/mmio_display_hex7seg.sv
// Nibble to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
// Used by mmio_display only when MMIO_DISPLAY_HEX_EN is defined.
module hex7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // glyph lookup
  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      default: seg_o = 7'h0E;
    endcase
  end

endmodule

// File: rtl/mmio_display.sv
// Memory-mapped LED + 4-digit multiplexed seven-segment controller.
// MMIO_DISPLAY_HEX_EN: hex-decoded nibbles; otherwise raw segment bytes.
module mmio_display
  import mmio_display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
  parameter int unsigned SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        sel,
  output logic [7:0]  led,
  output logic [6:0]  seg,
  output logic [3:0]  ano
);

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

  logic [7:0]       led_q;
  logic [DIG_W-1:0] digits_q;
  logic [1:0]       ctrl_q;
  logic [19:0]      div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      frame_q, frame_d;
  logic [DIG_W-1:0] shadow_q, shadow_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       ano_q, ano_d;

  logic [3:0] off;
  logic       en, blz, blank;
  logic [6:0] glyph;
  logic [3:0] empty, lead;
  logic       unused_ok;

  assign sel = (addr[31:4] == BASE_ADDR[31:4]);
  assign off = {addr[3:2], 2'b00};
  assign en  = ctrl_q[CTRL_EN];
  assign blz = ctrl_q[CTRL_BLZ];
  assign led = led_q;
  assign seg = seg_q;
  assign ano = ano_q;
  assign unused_ok = ^{addr[1:0], wr_data};

`ifdef MMIO_DISPLAY_HEX_EN
  logic [3:0] nib;
  assign nib = shadow_q[{idx_q, 2'b00} +: 4];
  hex7seg u_dec (
    .nib_i (nib),
    .seg_o (glyph)
  );
  // a digit is empty when its nibble is zero
  always_comb begin
    empty = '0;
    for (int i = 0; i < 4; i++)
      empty[i] = (shadow_q[4*i +: 4] == 4'h0);
  end
`else
  assign glyph = shadow_q[{idx_q, 3'b000} +: 7];
  // a digit is empty when all its segments are off
  always_comb begin
    empty = '0;
    for (int i = 0; i < 4; i++)
      empty[i] = (shadow_q[8*i +: 8] == 8'hFF);
  end
`endif

  // leading-empty run from the top digit down; digit 0 never blanks
  always_comb begin
    lead    = '0;
    lead[3] = empty[3];
    lead[2] = empty[2] & lead[3];
    lead[1] = empty[1] & lead[2];
    blank   = blz & lead[idx_q];
  end

  // CPU register writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q    <= '0;
      digits_q <= DIG_RST;
      ctrl_q   <= CTRL_RST;
    end else if (wr_en && sel) begin
      case (off)
        OFF_LED:    led_q    <= wr_data[7:0];
        OFF_DIGITS: digits_q <= wr_data[DIG_W-1:0];
        OFF_CTRL:   ctrl_q   <= wr_data[1:0];
        default:    ;
      endcase
    end
  end

  // combinational read mux for same-cycle MEM return
  always_comb begin
    rd_data = '0;
    if (rd_en && sel) begin
      case (off)
        OFF_LED:    rd_data = {24'h0, led_q};
        OFF_DIGITS: rd_data = 32'(digits_q);
        OFF_CTRL:   rd_data = {30'h0, ctrl_q};
        default:    rd_data = {frame_q, 14'h0, idx_q};
      endcase
    end
  end

  // scan divider, digit index, frame count, anti-tear shadow
  always_comb begin
    div_d    = div_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    shadow_d = shadow_q;
    if (!en) begin
      div_d    = '0;
      idx_d    = '0;
      frame_d  = '0;
      shadow_d = digits_q;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        shadow_d = digits_q;
        frame_d  = frame_q + 16'd1;
      end
    end else begin
      div_d = div_q + 20'd1;
    end
  end

  // pin drive for the current digit; blanked digits go fully dark
  always_comb begin
    seg_d = SEG_BLANK;
    ano_d = 4'hF;
    if (en && !blank) begin
      seg_d = glyph;
      ano_d = ~(4'b0001 << idx_q);
    end
  end

  // scan state and registered pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      shadow_q <= DIG_RST;
      seg_q    <= SEG_BLANK;
      ano_q    <= 4'hF;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      ano_q    <= ano_d;
    end
  end

endmodule

// File: tb/tb_mmio_display.sv
// Scoreboard bench for mmio_display: a time-based reference model pushes
// expectations; monitors compare read path and registered pins.
module tb_mmio_display;

  localparam int SD = 4;
  localparam logic [31:0] BASE = 32'h4000_0010;
`ifdef MMIO_DISPLAY_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wr_data, rd_data;
  logic        wr_en, rd_en, sel;
  logic [7:0]  led;
  logic [6:0]  seg;
  logic [3:0]  ano;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        sel;
  } rd_exp_t;

  typedef struct packed {
    logic [7:0] led;
    logic [6:0] seg;
    logic [3:0] ano;
  } disp_exp_t;

  rd_exp_t   q_rd[$];
  disp_exp_t q_disp[$];

  // reference model state
  logic [7:0]  m_led;
  logic [31:0] m_dig;
  logic [1:0]  m_ctrl;
  logic [31:0] m_shadow;
  int          m_t;

  mmio_display #(.BASE_ADDR(BASE), .SCAN_DIV(SD)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .sel     (sel),
    .led     (led),
    .seg     (seg),
    .ano     (ano)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexglyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic bit dig_empty(input int i);
    if (HEX) return m_shadow[4*i +: 4] == 4'h0;
    return m_shadow[8*i +: 8] == 8'hFF;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] w);
    int idx, frame;
    idx   = (m_t / SD) % 4;
    frame = (m_t / (4 * SD)) % 65536;
    case (w)
      2'd0: return {24'h0, m_led};
      2'd1: return m_dig;
      2'd2: return {30'h0, m_ctrl};
      default: return {frame[15:0], 14'h0, idx[1:0]};
    endcase
  endfunction

  // pins after the coming edge, from the state before it
  function automatic disp_exp_t model_pins(input logic [7:0] nled);
    disp_exp_t e;
    int idx, msd;
    e.led = nled;
    e.seg = 7'h7F;
    e.ano = 4'hF;
    if (m_ctrl[0]) begin
      idx = (m_t / SD) % 4;
      msd = 0;
      for (int i = 0; i < 4; i++)
        if (!dig_empty(i)) msd = i;
      if (!(m_ctrl[1] && idx > msd)) begin
        e.seg = HEX ? hexglyph(m_shadow[4*idx +: 4])
                    : m_shadow[8*idx +: 7];
        e.ano = 4'hF;
        e.ano[idx] = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    m_led    = '0;
    m_dig    = HEX ? 32'h0 : 32'hFFFF_FFFF;
    m_shadow = m_dig;
    m_ctrl   = 2'b01;
    m_t      = 0;
  endtask

  task automatic cycle(input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
    logic s;
    logic [7:0] nled;
    rd_exp_t er;
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wr_data = d;
    s = (a[31:4] == BASE[31:4]);
    er.sel = s;
    er.rd  = (r && s) ? model_read(a[3:2]) : 32'h0;
    q_rd.push_back(er);
    nled = (w && s && a[3:2] == 2'd0) ? d[7:0] : m_led;
    q_disp.push_back(model_pins(nled));
    if (m_ctrl[0]) begin
      m_t++;
      if (m_t % (4 * SD) == 0) m_shadow = m_dig;
    end else begin
      m_t = 0;
      m_shadow = m_dig;
    end
    if (w && s) begin
      case (a[3:2])
        2'd0: m_led  = d[7:0];
        2'd1: m_dig  = HEX ? {16'h0, d[15:0]} : d;
        2'd2: m_ctrl = d[1:0];
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n, input logic r, input logic [31:0] a);
    for (int i = 0; i < n; i++) cycle(1'b0, r, a, 32'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // pin monitor
  always @(posedge clk) begin
    disp_exp_t e;
    #1;
    if (q_disp.size() > 0) begin
      e = q_disp.pop_front();
      n_cmp++;
      if ({led, seg, ano} !== e) begin
        n_bad++;
        $display("FAIL pins t=%0t led/seg/ano got %h/%h/%h want %h/%h/%h",
                 $time, led, seg, ano, e.led, e.seg, e.ano);
      end
    end
  end

  // read-path monitor
  always @(negedge clk) begin
    rd_exp_t e;
    #2;
    if (q_rd.size() > 0) begin
      e = q_rd.pop_front();
      n_cmp++;
      if ({rd_data, sel} !== e) begin
        n_bad++;
        $display("FAIL read t=%0t addr %h rd/sel got %h/%b want %h/%b",
                 $time, addr, rd_data, sel, e.rd, e.sel);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int op;
    reset = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; addr = BASE; wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ano", 32'(ano), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_rd", rd_data, 32'h0);
    #2 reset = 1'b0;

    idle(2, 1'b0, BASE);
    cycle(1'b1, 1'b0, BASE + 4, 32'h0000_1234);
    cycle(1'b0, 1'b1, BASE + 4, 32'h0);
    idle(40, 1'b1, BASE + 12);

    idle(5, 1'b0, BASE);
    cycle(1'b1, 1'b0, BASE + 4, 32'h4040_BEEF);
    idle(40, 1'b1, BASE + 12);

    cycle(1'b1, 1'b0, BASE + 8, 32'h0);
    idle(6, 1'b1, BASE + 12);
    cycle(1'b1, 1'b0, BASE + 4, 32'h0000_0A7C);
    cycle(1'b1, 1'b0, BASE + 8, 32'h1);
    idle(20, 1'b1, BASE + 12);

    cycle(1'b1, 1'b0, BASE + 8, 32'h3);
    cycle(1'b1, 1'b0, BASE + 4, 32'h0000_0050);
    idle(20, 1'b1, BASE + 8);
    cycle(1'b1, 1'b0, BASE + 4, 32'h0);
    idle(20, 1'b0, BASE);
    cycle(1'b1, 1'b0, BASE + 4, 32'hFFFF_4079);
    idle(20, 1'b0, BASE);

    cycle(1'b1, 1'b1, BASE + 0, 32'hFFFF_FFA5);
    cycle(1'b1, 1'b1, BASE + 12, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, BASE + 16, 32'h0000_005A);
    cycle(1'b0, 1'b1, BASE + 16, 32'h0);
    cycle(1'b0, 1'b1, BASE - 4, 32'h0);
    idle(4, 1'b1, BASE + 12);

    // asynchronous reset mid-scan
    @(posedge clk);
    #3;
    wr_en = 1'b0; rd_en = 1'b1; addr = BASE + 12;
    reset = 1'b1;
    #1;
    chk("midrst_ano", 32'(ano), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_led", 32'(led), 32'h0);
    chk("midrst_status", rd_data, 32'h0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    idle(6, 1'b0, BASE);

    for (int k = 0; k < 800; k++) begin
      op = $urandom_range(0, 9);
      d  = $urandom;
      a  = BASE + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      if (op == 9)
        a = ($urandom_range(0, 1) == 1) ? BASE + 32'h10 + $urandom_range(0, 15)
                                        : $urandom;
      if (a[3:2] == 2'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      if (a[3:2] == 2'd1 && $urandom_range(0, 2) == 0) d = d & 32'h0000_00F0;
      cycle(op < 4 || op == 9, 1'(($urandom_range(0, 1))), a, d);
    end

    cycle(1'b0, 1'b0, BASE, 32'h0);
    @(posedge clk);
    #3;
    chk("queues_drained", 32'(q_rd.size() + q_disp.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
